paddle_input_ctrl: RTL and testbench



---
 rtl/paddle_pkg.sv | 21 ++
 rtl/btn_debounce.sv | 40 ++++
 rtl/paddle_input_ctrl.sv | 136 +++++++++++++
 tb/tb_paddle_input_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/paddle_pkg.sv
// Shared types and constants for the paddle input controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package paddle_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } paddle_state_t;

    // Bit positions of one player's {down,up} pair inside the held bus
    localparam int HELD_UP_BIT   = 0;
    localparam int HELD_DOWN_BIT = 1;

    // Signed velocity needs one bit more than the magnitude
    function automatic int vel_w(input int speed_w);
        return speed_w + 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: invert, 2-FF synchronise, accept a change after DEBOUNCE_CYCLES stable cycles.
// Latency: 2 + DEBOUNCE_CYCLES cycles from pin edge to btn_db.
// Backpressure: none; free-running level path.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_n,
    output logic btn_db
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] stable_cnt;

    // Counter only runs while the synchronised level disagrees with the accepted one
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_a     <= 1'b0;
            sync_b     <= 1'b0;
            btn_db     <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync_a <= ~btn_n;
            sync_b <= sync_a;
            if (sync_b == btn_db) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                btn_db     <= sync_b;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/paddle_input_ctrl.sv
// Per-player paddle controller: merges PS/2 and debounced buttons, frame-sampled FSM -> signed velocity.
// Latency: vel updates the cycle after frame_tick; PS/2 reaches held combinationally. PADDLE_ACCEL_EN enables acceleration.
// Backpressure: none; levels are sampled once per frame and anything between ticks is dropped.
module paddle_input_ctrl
    import paddle_pkg::*;
#(
    parameter int N_PLAYERS       = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int SPEED_W         = 4,
    parameter int MAX_SPEED       = 8,
    parameter int ACCEL_FRAMES    = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             vsync,
    input  logic [N_PLAYERS-1:0]             ps2_up,
    input  logic [N_PLAYERS-1:0]             ps2_down,
    input  logic [N_PLAYERS-1:0]             btn_up_n,
    input  logic [N_PLAYERS-1:0]             btn_down_n,
    output logic                             frame_tick,
    output logic [2*N_PLAYERS-1:0]           held,
    output logic [N_PLAYERS*(SPEED_W+1)-1:0] vel
);

    localparam int VW = vel_w(SPEED_W);

    logic [N_PLAYERS-1:0] up_db;
    logic [N_PLAYERS-1:0] dn_db;
    logic                 vsync_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) vsync_q <= 1'b0;
        else       vsync_q <= vsync;
    end

    assign frame_tick = vsync_q & ~vsync;

    // Gated so the merged bus reads released while reset is asserted, whatever the PS/2 levels
    always_comb begin
        held = '0;
        if (!reset) begin
            for (int i = 0; i < N_PLAYERS; i++) begin
                held[2*i+HELD_UP_BIT]   = ps2_up[i]   | up_db[i];
                held[2*i+HELD_DOWN_BIT] = ps2_down[i] | dn_db[i];
            end
        end
    end

    for (genvar i = 0; i < N_PLAYERS; i++) begin : g_player
        logic          up_i;
        logic          dn_i;
        paddle_state_t state_q;
        paddle_state_t state_nx;
        paddle_state_t target;
        logic [SPEED_W-1:0] mag;
        logic [VW-1:0]      mag_ext;

        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
            .clock (clock), .reset (reset), .btn_n (btn_up_n[i]),   .btn_db (up_db[i])
        );
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
            .clock (clock), .reset (reset), .btn_n (btn_down_n[i]), .btn_db (dn_db[i])
        );

        assign up_i = ps2_up[i]   | up_db[i];
        assign dn_i = ps2_down[i] | dn_db[i];

        // Pressing both directions cancels out to IDLE
        always_comb begin
            target = IDLE;
            if (up_i && !dn_i)      target = UP;
            else if (dn_i && !up_i) target = DOWN;
        end

`ifdef PADDLE_ACCEL_EN
        localparam int HW = $clog2(ACCEL_FRAMES + 1);
        logic [SPEED_W-1:0] mag_q;
        logic [SPEED_W-1:0] mag_nx;
        logic [HW-1:0]      hold_q;
        logic [HW-1:0]      hold_nx;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                state_q <= IDLE;
                mag_q   <= '0;
                hold_q  <= '0;
            end else begin
                state_q <= state_nx;
                mag_q   <= mag_nx;
                hold_q  <= hold_nx;
            end
        end

        always_comb begin
            state_nx = state_q;
            mag_nx   = mag_q;
            hold_nx  = hold_q;
            if (frame_tick) begin
                state_nx = target;
                if (target == IDLE) begin
                    mag_nx  = '0;
                    hold_nx = '0;
                end else if (target != state_q) begin
                    // Fresh press or direct reversal restarts from the slowest speed
                    mag_nx  = SPEED_W'(1);
                    hold_nx = '0;
                end else if (hold_q == HW'(ACCEL_FRAMES - 1)) begin
                    hold_nx = '0;
                    if (mag_q < SPEED_W'(MAX_SPEED)) mag_nx = mag_q + SPEED_W'(1);
                end else begin
                    hold_nx = hold_q + HW'(1);
                end
            end
        end

        assign mag = mag_q;
`else
        always_ff @(posedge clock or posedge reset) begin
            if (reset) state_q <= IDLE;
            else       state_q <= state_nx;
        end

        always_comb begin
            state_nx = state_q;
            if (frame_tick) state_nx = target;
        end

        assign mag = (state_q == IDLE) ? '0 : SPEED_W'(MAX_SPEED);
`endif

        assign mag_ext = VW'(mag);
        assign vel[i*VW +: VW] = (state_q == UP)   ? -mag_ext :
                                 (state_q == DOWN) ?  mag_ext : '0;
    end

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// Directed bench for paddle_input_ctrl with small debounce/acceleration parameters.
// Expected velocities follow whether PADDLE_ACCEL_EN is defined for the build.
module tb_paddle_input_ctrl;

    localparam int NP  = 2;
    localparam int DB  = 4;
    localparam int SW  = 4;
    localparam int MAX = 3;
    localparam int AF  = 2;
    localparam int VW  = SW + 1;
`ifdef PADDLE_ACCEL_EN
    localparam bit ACCEL = 1'b1;
`else
    localparam bit ACCEL = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              vsync;
    logic [NP-1:0]     ps2_up, ps2_down, btn_up_n, btn_down_n;
    logic              frame_tick;
    logic [2*NP-1:0]   held;
    logic [NP*VW-1:0]  vel;

    int vectors = 0;
    int miscompares = 0;

    paddle_input_ctrl #(
        .N_PLAYERS(NP), .DEBOUNCE_CYCLES(DB), .SPEED_W(SW),
        .MAX_SPEED(MAX), .ACCEL_FRAMES(AF)
    ) dut (
        .clock(clock), .reset(reset), .vsync(vsync),
        .ps2_up(ps2_up), .ps2_down(ps2_down),
        .btn_up_n(btn_up_n), .btn_down_n(btn_down_n),
        .frame_tick(frame_tick), .held(held), .vel(vel)
    );

    always #5 clock = ~clock;

    function automatic logic signed [VW-1:0] vel_of(input int p);
        return $signed(vel[p*VW +: VW]);
    endfunction

    // Expected magnitude after n frames of continuous hold (n starts at 1)
    function automatic int exp_mag(input int n);
        int m;
        if (!ACCEL) return MAX;
        m = 1 + (n - 1) / AF;
        return (m > MAX) ? MAX : m;
    endfunction

    // Produces one vsync falling edge; reports the pulse and any extra pulses while vsync stays low
    task automatic do_frame(output logic seen, output int extra);
        vsync = 1'b1;
        repeat (2) @(posedge clock);
        #1 vsync = 1'b0;
        #1 seen = frame_tick;
        @(posedge clock); #1;
        extra = 0;
        repeat (3) begin
            if (frame_tick) extra++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset();
        logic seen; int extra; int cnt;
        logic signed [VW-1:0] v;
        ps2_up = 2'b01;
        do_frame(seen, extra);
        v = vel_of(0);
        vectors++;
        if (v !== VW'(-exp_mag(1))) begin
            miscompares++; $display("FAIL pre_reset_vel0 got=%0d exp=%0d", v, -exp_mag(1));
        end
        // Mid-frame reset with arbitrary inputs
        vsync = 1'b1; ps2_up = 2'b11; ps2_down = 2'b10; btn_up_n = 2'b00; btn_down_n = 2'b01;
        @(posedge clock); #3 reset = 1'b1;
        #1;
        vectors++;
        if (vel !== '0 || held !== '0 || frame_tick !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs vel=%h held=%b tick=%b exp 0/0/0", vel, held, frame_tick);
        end
        vsync = 1'b0;
        ps2_up = '0; ps2_down = '0; btn_up_n = '1; btn_down_n = '1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        // vsync already low at release: no tick may be synthesised
        cnt = 0;
        repeat (4) begin
            #1 if (frame_tick) cnt++;
            @(posedge clock); #1;
        end
        vectors++;
        if (cnt !== 0) begin
            miscompares++; $display("FAIL no_tick_after_reset got=%0d exp=0", cnt);
        end
        do_frame(seen, extra);
        vectors++;
        if (seen !== 1'b1 || extra !== 0) begin
            miscompares++; $display("FAIL first_tick seen=%b extra=%0d exp 1/0", seen, extra);
        end
        vectors++;
        if (vel !== '0 || held !== '0) begin
            miscompares++; $display("FAIL post_reset_idle vel=%h held=%b exp 0/0", vel, held);
        end
    endtask

    task automatic test_debounce();
        logic glitch; int first;
        glitch = 1'b0;
        for (int k = 0; k < 10; k++) begin
            btn_up_n[0] = k[0];
            repeat (2) begin
                @(posedge clock); #1;
                if (held[0]) glitch = 1'b1;
            end
        end
        vectors++;
        if (glitch !== 1'b0) begin
            miscompares++; $display("FAIL debounce_bounce held0 rose=%b exp 0", glitch);
        end
        btn_up_n[0] = 1'b0;
        first = 0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clock); #1;
            if (held[0] && first == 0) first = n;
        end
        vectors++;
        if (first < DB + 1 || first > DB + 3) begin
            miscompares++; $display("FAIL debounce_latency got=%0d exp=%0d..%0d", first, DB + 1, DB + 3);
        end
        vectors++;
        if (held !== 4'b0001) begin
            miscompares++; $display("FAIL debounce_held got=%b exp=0001", held);
        end
        btn_up_n[0] = 1'b1;
        repeat (12) @(posedge clock);
        #1;
        vectors++;
        if (held !== 4'b0000) begin
            miscompares++; $display("FAIL debounce_release got=%b exp=0000", held);
        end
    endtask

    task automatic test_accel();
        logic seen; int extra;
        logic signed [VW-1:0] v0, v1;
        ps2_down[1] = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            do_frame(seen, extra);
            v0 = vel_of(0); v1 = vel_of(1);
            vectors++;
            if (v1 !== VW'(exp_mag(n)) || v0 !== '0) begin
                miscompares++;
                $display("FAIL accel_frame%0d vel1=%0d vel0=%0d exp %0d/0", n, v1, v0, exp_mag(n));
            end
        end
        ps2_down[1] = 1'b0;
        do_frame(seen, extra);
        vectors++;
        if (vel !== '0) begin
            miscompares++; $display("FAIL accel_release vel=%h exp=0", vel);
        end
    endtask

    task automatic test_reversal();
        logic seen; int extra;
        logic signed [VW-1:0] v;
        ps2_up[0] = 1'b1;
        repeat (5) do_frame(seen, extra);
        v = vel_of(0);
        vectors++;
        if (v !== VW'(-MAX)) begin
            miscompares++; $display("FAIL reversal_up_sat got=%0d exp=%0d", v, -MAX);
        end
        ps2_up[0] = 1'b0; ps2_down[0] = 1'b1;
        do_frame(seen, extra);
        v = vel_of(0);
        vectors++;
        if (v !== VW'(exp_mag(1))) begin
            miscompares++; $display("FAIL reversal_down got=%0d exp=%0d", v, exp_mag(1));
        end
        ps2_down[0] = 1'b0;
        do_frame(seen, extra);
    endtask

    task automatic test_conflict();
        logic seen; int extra;
        logic signed [VW-1:0] v;
        ps2_up[0] = 1'b1;
        do_frame(seen, extra);
        ps2_down[0] = 1'b1;
        #1;
        vectors++;
        if (held !== 4'b0011) begin
            miscompares++; $display("FAIL conflict_held got=%b exp=0011", held);
        end
        do_frame(seen, extra);
        v = vel_of(0);
        vectors++;
        if (v !== '0) begin
            miscompares++; $display("FAIL conflict_idle got=%0d exp=0", v);
        end
        ps2_down[0] = 1'b0;
        do_frame(seen, extra);
        v = vel_of(0);
        vectors++;
        if (v !== VW'(-exp_mag(1))) begin
            miscompares++; $display("FAIL conflict_release got=%0d exp=%0d", v, -exp_mag(1));
        end
        ps2_up[0] = 1'b0;
        do_frame(seen, extra);
    endtask

    task automatic test_between_ticks();
        logic seen; int extra;
        logic signed [VW-1:0] v;
        ps2_up[1] = 1'b1;
        #1;
        vectors++;
        if (held !== 4'b0100) begin
            miscompares++; $display("FAIL ps2_held_comb got=%b exp=0100", held);
        end
        repeat (3) @(posedge clock);
        #1 ps2_up[1] = 1'b0;
        do_frame(seen, extra);
        v = vel_of(1);
        vectors++;
        if (v !== '0) begin
            miscompares++; $display("FAIL short_press_ignored got=%0d exp=0", v);
        end
    endtask

    initial begin
        reset = 1'b1; vsync = 1'b1;
        ps2_up = '0; ps2_down = '0; btn_up_n = '1; btn_down_n = '1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        test_debounce();
        test_accel();
        test_reversal();
        test_conflict();
        test_between_ticks();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
